// File: rtl/rx_demux_if.sv
// rtl/rx_demux_if.sv - RX FIFO, CPU read port and block FIFO signals of the receive demux
interface rx_demux_if #(
    parameter int CNT_W = 16
);
    logic             sel;
    logic [31:0]      rx_data;
    logic             rx_empty;
    logic             rx_read;
    logic             cpu_rd_rx_require;
    logic [31:0]      cpu_rd_rx_data;
    logic             cpu_rd_rx_valid;
    logic [127:0]     blk_data;
    logic             blk_write;
    logic             blk_full;
    logic [CNT_W-1:0] blk_count;

    // The demux side: it pops the RX FIFO and pushes the block FIFO.
    modport master (
        input  sel, rx_data, rx_empty, cpu_rd_rx_require, blk_full,
        output rx_read, cpu_rd_rx_data, cpu_rd_rx_valid, blk_data, blk_write, blk_count
    );

    // The platform side: FIFOs, CPU register block and mode control.
    modport slave (
        output sel, rx_data, rx_empty, cpu_rd_rx_require, blk_full,
        input  rx_read, cpu_rd_rx_data, cpu_rd_rx_valid, blk_data, blk_write, blk_count
    );
endinterface

// File: rtl/rx_demux.sv
// rtl/rx_demux.sv - packs four 32-bit RX words into a 128-bit block, or lends the RX FIFO to the CPU
module rx_demux #(
    parameter int CNT_W = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    rx_demux_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        CPU,
        W0,
        W1,
        W2,
        W3,
        PUSH
    } state_t;

    state_t           state_q, state_d;
    logic [127:0]     blk_data_q;
    logic [CNT_W-1:0] blk_count_q;

    logic             rx_read_c;
    logic             blk_write_c;
    logic             cpu_valid_c;
    logic [31:0]      cpu_data_c;
    logic             cap_en_c;
    logic [1:0]       cap_slot_c;

    // State register; reset abandons any partial block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshakes; a pop only happens when the FIFO has a word.
    always_comb begin
        state_d     = state_q;
        rx_read_c   = 1'b0;
        blk_write_c = 1'b0;
        cpu_valid_c = 1'b0;
        cpu_data_c  = 32'd0;
        cap_en_c    = 1'b0;
        cap_slot_c  = 2'd0;
        case (state_q)
            IDLE: begin
                state_d = bus.sel ? CPU : W0;
            end
            CPU: begin
                cpu_data_c  = bus.rx_data;
                cpu_valid_c = ~bus.rx_empty;
                rx_read_c   = bus.cpu_rd_rx_require & ~bus.rx_empty;
                if (!bus.sel) begin
                    state_d = IDLE;
                end
            end
            W0: begin
                // Mode may only change here, before a block is started.
                if (bus.sel) begin
                    state_d = IDLE;
                end else begin
                    rx_read_c  = ~bus.rx_empty;
                    cap_en_c   = ~bus.rx_empty;
                    cap_slot_c = 2'd0;
                    if (!bus.rx_empty) begin
                        state_d = W1;
                    end
                end
            end
            W1: begin
                rx_read_c  = ~bus.rx_empty;
                cap_en_c   = ~bus.rx_empty;
                cap_slot_c = 2'd1;
                if (!bus.rx_empty) begin
                    state_d = W2;
                end
            end
            W2: begin
                rx_read_c  = ~bus.rx_empty;
                cap_en_c   = ~bus.rx_empty;
                cap_slot_c = 2'd2;
                if (!bus.rx_empty) begin
                    state_d = W3;
                end
            end
            W3: begin
                rx_read_c  = ~bus.rx_empty;
                cap_en_c   = ~bus.rx_empty;
                cap_slot_c = 2'd3;
                if (!bus.rx_empty) begin
                    state_d = PUSH;
                end
            end
            PUSH: begin
                blk_write_c = ~bus.blk_full;
                if (!bus.blk_full) begin
                    state_d = W0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Block register: word0 lands in the top lane, held untouched through PUSH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_data_q <= 128'd0;
        end else if (cap_en_c) begin
            case (cap_slot_c)
                2'd0:    blk_data_q[127:96] <= bus.rx_data;
                2'd1:    blk_data_q[95:64]  <= bus.rx_data;
                2'd2:    blk_data_q[63:32]  <= bus.rx_data;
                default: blk_data_q[31:0]   <= bus.rx_data;
            endcase
        end
    end

    // Delivered-block counter, free-running modulo 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_q <= '0;
        end else if (blk_write_c) begin
            blk_count_q <= blk_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.rx_read         = rx_read_c;
    assign bus.blk_write       = blk_write_c;
    assign bus.cpu_rd_rx_valid = cpu_valid_c;
    assign bus.cpu_rd_rx_data  = cpu_data_c;
    assign bus.blk_data        = blk_data_q;
    assign bus.blk_count       = blk_count_q;

endmodule

// File: tb/tb_rx_demux.sv
// tb/tb_rx_demux.sv - randomized self-checking bench for rx_demux against a queue-based block model
module tb_rx_demux;
    localparam int CNT_W = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rx_demux_if #(.CNT_W(CNT_W)) bus ();
    rx_demux #(.CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          checks = 0;
    int          failures = 0;
    logic [31:0] fifo[$];
    logic [31:0] pack_q[$];
    int          writes = 0;
    int          cyc = 0;
    bit          pop_pending = 0;
    bit          sel_v = 0, gap_v = 0, full_v = 0, req_v = 0;
    int          rd_log[$];
    int          wr_log[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_block();
        return {pack_q[0], pack_q[1], pack_q[2], pack_q[3]};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_read"},   128'(bus.rx_read), '0);
        check({tag, "_blk_write"}, 128'(bus.blk_write), '0);
        check({tag, "_cpu_valid"}, 128'(bus.cpu_rd_rx_valid), '0);
        check({tag, "_cpu_data"},  128'(bus.cpu_rd_rx_data), '0);
        check({tag, "_blk_count"}, 128'(bus.blk_count), '0);
        check({tag, "_blk_data"},  bus.blk_data, '0);
    endtask

    // Transaction-level model: every block written must be the next four packing-mode pops.
    task automatic monitor();
        int held;
        held = pack_q.size();
        check("rd_while_empty", 128'(bus.rx_read & bus.rx_empty), '0);
        check("wr_while_full", 128'(bus.blk_write & bus.blk_full), '0);
        check("blk_count", 128'(bus.blk_count), 128'(writes % (1 << CNT_W)));
        if (held == 4) begin
            check("push_data", bus.blk_data, model_block());
            check("push_write", 128'(bus.blk_write), 128'(!bus.blk_full));
            check("push_no_read", 128'(bus.rx_read), '0);
            if (bus.blk_write) begin
                pack_q.delete();
                writes++;
                wr_log.push_back(cyc);
            end
        end else begin
            check("no_early_write", 128'(bus.blk_write), '0);
            if (held > 0 && !bus.rx_empty) check("partial_must_read", 128'(bus.rx_read), 128'(1));
        end
        if (bus.cpu_rd_rx_valid) begin
            if (fifo.size() == 0) begin
                check("cpu_valid_on_empty", 128'(1), '0);
            end else begin
                check("cpu_data", 128'(bus.cpu_rd_rx_data), 128'(fifo[0]));
                check("cpu_read", 128'(bus.rx_read), 128'(req_v));
                check("cpu_no_partial", 128'(held), '0);
                if (bus.rx_read) pop_pending = 1;
            end
        end else begin
            if (!bus.rx_empty) check("cpu_idle_data", 128'(bus.cpu_rd_rx_data), '0);
            if (bus.rx_read && fifo.size() > 0 && !bus.rx_empty) begin
                pack_q.push_back(fifo[0]);
                pop_pending = 1;
                rd_log.push_back(cyc);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (pop_pending) begin
            fifo.delete(0);
            pop_pending = 0;
        end
        bus.sel               = sel_v;
        bus.blk_full          = full_v;
        bus.cpu_rd_rx_require = req_v;
        bus.rx_empty          = gap_v || (fifo.size() == 0);
        if (bus.rx_empty) bus.rx_data = $urandom;
        else              bus.rx_data = fifo[0];
        @(negedge clk);
        cyc++;
        if (rst_n) monitor();
    endtask

    task automatic run_until_held(input int n, input string tag);
        for (int i = 0; i < 200 && pack_q.size() != n; i++) step();
        check(tag, 128'(pack_q.size()), 128'(n));
    endtask

    task automatic run_until_write(input string tag);
        int w0;
        w0 = writes;
        for (int i = 0; i < 200 && writes == w0; i++) step();
        check(tag, 128'(writes - w0), 128'(1));
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        pop_pending = 0;
        #1;
        check_all_zero(tag);
        pack_q.delete();
        writes = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) fifo.push_back($urandom);
    endtask

    initial begin
        int          n0;
        int          exp_seq[5];
        logic [31:0] w[4];
        exp_seq = '{1, 2, 3, 0, 1};
        rst_n = 1'b0;
        bus.sel = 1'b0;
        bus.rx_empty = 1'b1;
        bus.rx_data = 32'd0;
        bus.cpu_rd_rx_require = 1'b0;
        bus.blk_full = 1'b0;
        #12;
        check_all_zero("reset");

        // Preloaded block, no stalls: four back-to-back pops then one push.
        fifo = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F};
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) step();
        check("first_rd_count", 128'(rd_log.size()), 128'(4));
        check("first_wr_count", 128'(wr_log.size()), 128'(1));
        if (rd_log.size() == 4) check("first_rd_span", 128'(rd_log[3] - rd_log[0]), 128'(3));
        if (rd_log.size() > 0 && wr_log.size() > 0)
            check("first_latency", 128'(wr_log[0] - rd_log[0]), 128'(4));
        check("first_block", bus.blk_data, 128'h000102030405060708090A0B0C0D0E0F);
        check("first_count", 128'(bus.blk_count), 128'(1));

        // RX runs dry between word 2 and word 3.
        push_words(4);
        run_until_held(2, "gap_reach");
        gap_v = 1;
        repeat (3) begin
            step();
            check("gap_no_read", 128'(bus.rx_read), '0);
        end
        gap_v = 0;
        n0 = wr_log.size();
        repeat (8) step();
        check("gap_one_write", 128'(wr_log.size() - n0), 128'(1));

        // Block FIFO full for five cycles while the next block's words wait.
        push_words(8);
        run_until_held(4, "stall_reach");
        full_v = 1;
        n0 = rd_log.size();
        repeat (5) begin
            step();
            check("stall_no_write", 128'(bus.blk_write), '0);
        end
        full_v = 0;
        step();
        check("stall_release_write", 128'(bus.blk_write), 128'(1));
        check("stall_no_read", 128'(rd_log.size() - n0), '0);
        repeat (10) step();

        // Mode change requested mid-block: block finishes first, then CPU mode.
        push_words(4);
        run_until_held(1, "sel_reach");
        sel_v = 1;
        run_until_held(0, "sel_block_done");
        repeat (3) step();
        fifo.push_back(32'hDEADBEEF);
        req_v = 1;
        step();
        check("cpu_valid", 128'(bus.cpu_rd_rx_valid), 128'(1));
        check("cpu_word", 128'(bus.cpu_rd_rx_data), 128'(32'hDEADBEEF));
        check("cpu_pop", 128'(bus.rx_read), 128'(1));
        check("cpu_no_write", 128'(bus.blk_write), '0);
        step();
        check("cpu_empty_read", 128'(bus.rx_read), '0);
        check("cpu_empty_valid", 128'(bus.cpu_rd_rx_valid), '0);
        sel_v = 0;
        req_v = 0;
        push_words(4);
        run_until_write("resume_write");

        // Counter wrap with a 2-bit counter.
        step();
        do_reset("idle_reset");
        for (int k = 0; k < 5; k++) begin
            push_words(4);
            run_until_write("wrap_write");
            step();
            check("wrap_count", 128'(bus.blk_count), 128'(exp_seq[k]));
        end

        // Reset after two words: partial block dropped, next block starts in the top lane.
        push_words(4);
        run_until_held(2, "midreset_reach");
        do_reset("mid_reset");
        fifo.delete();
        for (int i = 0; i < 4; i++) begin
            w[i] = $urandom;
            fifo.push_back(w[i]);
        end
        run_until_write("after_reset_write");
        check("after_reset_block", bus.blk_data, {w[0], w[1], w[2], w[3]});

        // Random traffic: mode flips, RX gaps, block FIFO back-pressure, CPU pops.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) sel_v = ~sel_v;
            gap_v  = ($urandom_range(0, 3) == 0);
            full_v = ($urandom_range(0, 2) == 0);
            req_v  = $urandom_range(0, 1);
            if (fifo.size() < 3) push_words($urandom_range(1, 4));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_demux.md
Name: rx_demux

Overview:
- Receive-side counterpart of the transmit-side 128-to-32 word splitter in the AES verify platform data path.
- Pops 32-bit words from the RX FIFO (first-word-fall-through) and packs four consecutive words into a 128-bit block. The block is pushed into the AES input block FIFO.
- With sel=1 the RX FIFO is handed to the CPU register interface for direct word reads instead.
- Also keeps a running count of blocks delivered, for platform status.

Parameters:
CNT_W, 16, width of blk_count; counter wraps modulo 2^CNT_W.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
sel  input  1  1 = CPU owns RX FIFO, 0 = block packing mode
rx_data  input  32  RX FIFO head word, valid when rx_empty=0
rx_empty  input  1  RX FIFO empty
rx_read  output  1  RX FIFO pop, one word per cycle high
cpu_rd_rx_require  input  1  CPU pop request (CPU mode)
cpu_rd_rx_data  output  32  RX head word to CPU (CPU mode, else 0)
cpu_rd_rx_valid  output  1  RX word available to CPU (CPU mode, else 0)
blk_data  output  128  assembled block, word0 in [127:96], word3 in [31:0]
blk_write  output  1  block FIFO push, one block per cycle high
blk_full  input  1  block FIFO full
blk_count  output  CNT_W  blocks pushed since reset

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, blk_data=0, blk_count=0.
  - All combinational outputs evaluate to 0: rx_read, blk_write, cpu_rd_rx_valid, cpu_rd_rx_data.
- FSM states: IDLE, CPU, W0, W1, W2, W3, PUSH.
- IDLE:
  - Next state is CPU if sel=1, else W0.
  - All outputs 0.
- CPU:
  - cpu_rd_rx_data = rx_data; cpu_rd_rx_valid = ~rx_empty; rx_read = cpu_rd_rx_require & ~rx_empty.
  - Stays in CPU while sel=1; sel=0 -> IDLE.
- W0 (no partial block held):
  - If sel=1 -> IDLE with no pop.
  - Else rx_read = ~rx_empty. On pop, rx_data is captured into blk_data[127:96] and the FSM moves to W1; otherwise it stays in W0.
- W1, W2, W3:
  - rx_read = ~rx_empty.
  - On pop, capture into [95:64], [63:32] and [31:0] respectively, then advance (W1->W2->W3->PUSH). Otherwise hold state.
  - sel is ignored: a started block always completes before any mode change.
- PUSH:
  - blk_write = ~blk_full; rx_read = 0.
  - On write, blk_count increments and the FSM goes to W0, where sel is re-evaluated. If blk_full, it holds in PUSH.
- blk_data:
  - Registered and only updated on a capture.
  - Stable throughout PUSH, so blk_data is valid whenever blk_write=1.
- Latency: the first pop of a block comes 1 cycle after entering W0. With no stalls, blk_write is asserted 4 cycles after the first pop. Throughput is 1 block per 5 cycles.
- rx_read is never asserted while rx_empty=1; blk_write is never asserted while blk_full=1.
- blk_count wraps from 2^CNT_W-1 to 0.
- Reset mid-block discards the partial block and returns to IDLE.

Test Plan:
- Reset, sel=0, RX preloaded with 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F -> four rx_read pulses on consecutive cycles; then one blk_write with blk_data=0x000102030405060708090A0B0C0D0E0F; blk_count=1.
- Empty RX between word 2 and word 3 for 3 cycles -> FSM holds in W2 with rx_read=0. The block completes with the correct word order, and blk_write fires only once.
- blk_full=1 for 5 cycles in PUSH -> blk_write=0 and blk_data held. blk_write=1 in the cycle blk_full drops; no extra rx_read during the stall.
- sel raised after the first word of a block -> the block completes and is pushed, then W0->IDLE->CPU. rx_data=0xDEADBEEF with cpu_rd_rx_require=1 -> cpu_rd_rx_valid=1, cpu_rd_rx_data=0xDEADBEEF, rx_read=1; no blk_write.
- CPU mode with rx_empty=1 and cpu_rd_rx_require=1 -> rx_read=0, cpu_rd_rx_valid=0. sel back to 0 -> IDLE then W0, and packing resumes.
- CNT_W=2, push 5 blocks -> blk_count sequence 1,2,3,0,1. Assert rst_n=0 after word 2 of the next block -> all outputs 0 immediately, and the next block starts at [127:96].
